// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline control unit
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_use_rs_i,
    input  logic       id_use_rt_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rt_i,
    output logic       lu_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_use_rs_i && (id_rs_i == ex_rt_i);
    assign rt_hit = id_use_rt_i && (id_rt_i == ex_rt_i);
    // A load into r0 is discarded, so it never creates a dependency.
    assign lu_o   = ex_memread_i && (ex_rt_i != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/freeze control for the 5-stage pipeline
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             mem_pcsrc_i,
    input  logic             mem_access_i,
    input  logic             dm_ready_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_bubble_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    localparam int              WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d, wait_inc;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               lu;
    logic               w;
    logic               stall_evt;
    logic               flush_evt;

    load_use_detect u_lu (
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_use_rs_i  (id_use_rs_i),
        .id_use_rt_i  (id_use_rt_i),
        .ex_memread_i (ex_memread_i),
        .ex_rt_i      (ex_rt_i),
        .lu_o         (lu)
    );

    assign w        = mem_access_i && !dm_ready_i;
    assign wait_inc = wait_cnt_q + WAIT_W'(1);

    // Enables are gated by rst_i directly so the pipe stays frozen while reset is held.
    always_comb begin
        pc_en_o         = 1'b0;
        if_id_en_o      = 1'b0;
        id_ex_en_o      = 1'b0;
        ex_mem_en_o     = 1'b0;
        mem_wb_en_o     = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        ex_mem_flush_o  = 1'b0;
        mem_wb_bubble_o = 1'b0;
        stall_evt       = 1'b0;
        flush_evt       = 1'b0;
        if (rst_i && state_q != ST_ERROR) begin
            if (w) begin
                mem_wb_en_o     = 1'b1;
                mem_wb_bubble_o = 1'b1;
                stall_evt       = 1'b1;
            end else if (mem_pcsrc_i) begin
                pc_en_o        = 1'b1;
                if_id_en_o     = 1'b1;
                id_ex_en_o     = 1'b1;
                ex_mem_en_o    = 1'b1;
                mem_wb_en_o    = 1'b1;
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
                flush_evt      = 1'b1;
            end else if (lu) begin
                id_ex_en_o    = 1'b1;
                ex_mem_en_o   = 1'b1;
                mem_wb_en_o   = 1'b1;
                id_ex_flush_o = 1'b1;
                stall_evt     = 1'b1;
            end else begin
                pc_en_o     = 1'b1;
                if_id_en_o  = 1'b1;
                id_ex_en_o  = 1'b1;
                ex_mem_en_o = 1'b1;
                mem_wb_en_o = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != ST_ERROR) begin
            wait_cnt_d = w ? wait_inc : '0;
            if (stall_evt && stall_cnt_q != CNT_SAT) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush_evt && flush_cnt_q != CNT_SAT) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
            if (w && wait_inc == WAIT_W'(WAIT_MAX)) begin
                state_d = ST_ERROR;
            end else if (state_q == ST_RUN && w) begin
                state_d = ST_MEM_WAIT;
            end else if (state_q == ST_MEM_WAIT && dm_ready_i) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign err_o       = (state_q == ST_ERROR);

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the 5-stage pipelined CPU: detects load-use hazards, flushes wrong-path instructions when a branch resolves taken in MEM, and freezes the pipeline while a multi-cycle data-memory access is outstanding. It drives the write-enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It keeps saturating stall and flush counters and latches a sticky error on a memory-wait timeout.

## Interface
- CNT_W, 16, width of the performance counters
- WAIT_MAX, 64, max consecutive not-ready cycles before timeout error (≥1)

- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- id_rs_i  in  5  RS field of instruction in ID
- id_rt_i  in  5  RT field of instruction in ID
- id_use_rs_i  in  1  ID instruction reads RS
- id_use_rt_i  in  1  ID instruction reads RT
- ex_memread_i  in  1  instruction in EX is a load
- ex_rt_i  in  5  destination RT of the instruction in EX
- mem_pcsrc_i  in  1  branch in MEM resolved taken
- mem_access_i  in  1  MEM instruction is a load or store
- dm_ready_i  in  1  data memory completes the access this cycle
- pc_en_o  out  1  PC load enable
- if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  pipe register load enables
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o  out  1 each  load a bubble (all-zero control) instead of data
- mem_wb_bubble_o  out  1  MEM/WB loads a bubble
- state_o  out  2  current FSM state
- stall_cnt_o  out  CNT_W  cycles with any freeze or stall, saturating
- flush_cnt_o  out  CNT_W  taken-branch flush events, saturating
- err_o  out  1  sticky memory-wait timeout

## Operation
- FSM states are RUN=0, MEM_WAIT=1 and ERROR=2. The registered part is the state, the wait counter and the two perf counters. All enable and flush outputs are combinational (Mealy) from state and inputs.
- The load-use condition LU is: ex_memread_i, and ex_rt_i≠0, and either (id_use_rs_i and id_rs_i==ex_rt_i) or (id_use_rt_i and id_rt_i==ex_rt_i).
- The wait condition W is: mem_access_i and not dm_ready_i.
- Priority, highest first: ERROR, then W, then mem_pcsrc_i, then LU, then normal.
  - ERROR: all enables 0, all flushes 0, bubble 0.
  - W (freeze): pc/if_id/id_ex/ex_mem enables 0; mem_wb_en_o=1 with mem_wb_bubble_o=1. LU and branch are re-evaluated once the wait ends.
  - Branch: all enables 1; if_id_flush_o, id_ex_flush_o and ex_mem_flush_o all 1. Any simultaneous LU is discarded, because the dependent instruction is flushed.
  - LU: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; downstream enables stay 1. The stall lasts exactly one cycle, because the bubble clears the condition.
  - Normal: all enables 1, all flushes and bubble 0.
- FSM transitions:
  - RUN→MEM_WAIT when W holds.
  - MEM_WAIT→RUN on the first cycle with dm_ready_i=1. That cycle advances normally.
  - Any state→ERROR when the wait counter reaches WAIT_MAX.
  - ERROR holds until reset.
- Wait counter:
  - Cleared when W is false.
  - Incremented on each W cycle.
  - Compared against WAIT_MAX after incrementing.
- stall_cnt_o increments on each W or LU cycle. flush_cnt_o increments on each branch-flush cycle. Both saturate at 2^CNT_W−1.

## Timing
- While rst_i is low: state=RUN, counters=0, err_o=0, all enables and flushes forced to 0.
- The first cycle after reset release is in RUN with normal outputs.
- Outputs respond in the same cycle as the inputs; the pipe registers sample them on the next rising edge.
- Counter and state updates are visible one cycle after the causing event.
- err_o rises on the edge after the WAIT_MAX-th consecutive W cycle.
- Asserting rst_i mid-wait aborts the wait immediately (asynchronously).

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, ERROR) and its 2-bit encoding;
  - the register-zero constant 5'd0.
- One sub-module, load_use_detect, contains the purely combinational LU comparator, so the forwarding unit can reuse it later.
- The FSM, counters and output mux stay in pipe_hazard_ctrl.

## Test plan
- Load-use: apply ex_memread_i=1, ex_rt_i=8, id_rs_i=8, id_use_rs_i=1 for one cycle. Required: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, and stall_cnt_o=1 on the next cycle. Repeat with ex_rt_i=0: no stall.
- Taken branch: assert mem_pcsrc_i=1 together with a load-use match. Required: all three flushes 1, all enables 1, no stall, flush_cnt_o increments to 1.
- Memory wait: mem_access_i=1 with dm_ready_i=0 for 3 cycles, then 1. Required: freeze plus MEM/WB bubble for 3 cycles, state_o=1, then RUN with normal advance on the ready cycle; stall_cnt_o=3.
- Timeout: WAIT_MAX=4, dm_ready_i held 0. Required: err_o=1 and state_o=2 after 4 cycles; all enables stay 0 even after dm_ready_i=1.
- Reset mid-wait: assert rst_i=0 during MEM_WAIT. Required: outputs 0, counters 0, and on release state RUN with err_o=0.
- Saturation: CNT_W=3, force 10 stall cycles. Required: stall_cnt_o stops at 7.
